// File: rtl/mod_red_pkg.sv
// Shared definitions for the modular-reduction arbiter.
// Contents:
//   Q           - fixed reduction modulus (8380417)
//   DATA_WIDTH  - operand width fed to the reduction unit
//   Q_WIDTH     - reduced result width
//   red_state_e - sequencer state encoding (2-bit IDLE/ISSUE/WAIT/RESP)
package mod_red_pkg;

    localparam int unsigned Q          = 8380417;
    localparam int unsigned DATA_WIDTH = 48;
    localparam int unsigned Q_WIDTH    = 23;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } red_state_e;

endpackage

// File: rtl/mod_red_rr_arbiter.sv
// Combinational round-robin grant selection.
// Ports:
//   req       in  NUM_REQ  request vector
//   ptr       in  IDX_W    index given highest priority this cycle
//   grant     out NUM_REQ  one-hot grant (zero when nothing requested)
//   grant_idx out IDX_W    index of the granted requester
//   any_valid out 1        at least one request present
module mod_red_rr_arbiter
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_valid
);

    import mod_red_pkg::*;

    int unsigned cand;

    // Walk the requesters cyclically starting at ptr; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        cand      = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (32'(ptr) + off) % NUM_REQ;
            if (!any_valid && req[cand]) begin
                any_valid   = 1'b1;
                grant_idx   = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_red_arbiter.sv
// Round-robin arbiter/sequencer sharing one Barrett reduction unit (q = 8380417)
// among NUM_REQ requesters. One reduction in flight at a time.
// Optional feature macro: MOD_RED_ARB_WATCHDOG_EN (adds TIMEOUT_CYCLES and err).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     in  NUM_REQ             per-requester request valid
//   req_ready     out NUM_REQ             per-requester accept (IDLE only)
//   req_data      in  NUM_REQ*DATA_WIDTH  operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid     out NUM_REQ             per-requester response valid
//   rsp_ready     in  NUM_REQ             per-requester response accept
//   rsp_data      out Q_WIDTH             shared result bus
//   red_start     out 1                   one-cycle start pulse to reduction unit
//   red_data_in   out DATA_WIDTH          operand to reduction unit
//   red_done      in  1                   reduction complete pulse
//   red_data_out  in  Q_WIDTH             reduction result, valid with red_done
//   busy          out 1                   not in IDLE
//   err           out 1                   sticky watchdog error (watchdog build only)
module mod_red_arbiter
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = mod_red_pkg::DATA_WIDTH,
    parameter int unsigned Q_WIDTH    = mod_red_pkg::Q_WIDTH,
    parameter int unsigned IDX_W      = $clog2(NUM_REQ)
`ifdef MOD_RED_ARB_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [Q_WIDTH-1:0]            rsp_data,
    output logic                          red_start,
    output logic [DATA_WIDTH-1:0]         red_data_in,
    input  logic                          red_done,
    input  logic [Q_WIDTH-1:0]            red_data_out,
    output logic                          busy
`ifdef MOD_RED_ARB_WATCHDOG_EN
    ,
    output logic                          err
`endif
);

    import mod_red_pkg::*;

    red_state_e              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        gnt_idx_q;
    logic [DATA_WIDTH-1:0]   opnd_q;
    logic [Q_WIDTH-1:0]      res_q, res_d;
    logic                    accept;
    logic                    res_load;

    logic [NUM_REQ-1:0]      arb_grant;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_any;
    logic [DATA_WIDTH-1:0]   req_slice;

    mod_red_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_valid (arb_any)
    );

    assign req_slice = req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];

`ifdef MOD_RED_ARB_WATCHDOG_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          err_q, err_d;
    logic          wd_expire;

    // Counter restarts in ISSUE so it reads zero on the first WAIT cycle.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == StIssue) begin
            wd_cnt_d = '0;
        end else if (state_q == StWait) begin
            wd_cnt_d = wd_cnt_q + CW'(1);
        end
    end

    assign wd_expire = (state_q == StWait) && (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`endif

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        accept   = 1'b0;
        res_load = 1'b0;
        res_d    = red_data_out;
`ifdef MOD_RED_ARB_WATCHDOG_EN
        err_d    = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (arb_any) begin
                    accept  = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (red_done) begin
                    res_load = 1'b1;
                    state_d  = StResp;
                end
`ifdef MOD_RED_ARB_WATCHDOG_EN
                // Release the requester with a zero result rather than hang.
                else if (wd_expire) begin
                    res_load = 1'b1;
                    res_d    = '0;
                    err_d    = 1'b1;
                    state_d  = StResp;
                end
`endif
            end
            StResp: begin
                if (rsp_ready[gnt_idx_q]) begin
                    ptr_d   = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            opnd_q    <= '0;
            res_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (accept) begin
                opnd_q    <= req_slice;
                gnt_idx_q <= arb_idx;
            end
            if (res_load) begin
                res_q <= res_d;
            end
        end
    end

    // Handshake outputs.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_q == StIdle) begin
            req_ready = arb_grant;
        end
        if (state_q == StResp) begin
            rsp_valid[gnt_idx_q] = 1'b1;
        end
    end

    assign red_start   = (state_q == StIssue);
    assign red_data_in = opnd_q;
    assign rsp_data    = res_q;
    assign busy        = (state_q != StIdle);

endmodule
